line_sensor_adc_reader: RTL and testbench

Drives the DE0-Nano on-board ADC128S022 over SPI and scans the three line-sensor channels (left, center, right) round-robin. It compares each 12-bit sample against a threshold and registers the classified robot orientation on `bot_orientation`. This block is the producer of the 4-bit orientation code consumed by the motor-control block in line-sensor mode. It also exposes raw samples and a per-scan valid strobe for debug and calibration.

---
 rtl/line_sensor_adc_reader.sv | 187 ++++++++++++++++++
 tb/tb_line_sensor_adc_reader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_sensor_adc_reader.sv
// line_sensor_adc_reader: scans the left/center/right line sensors on the
// ADC128S022 over SPI and classifies the robot orientation once per scan.
//
// state  | meaning
// S_GAP  | cs_n high, sclk high; inter-frame gap, waits for enable at terminal count
// S_LOW  | cs_n low, sclk low for CLK_DIV clks; din presented for this bit
// S_HIGH | cs_n low, sclk high for CLK_DIV clks; ends frame after bit 15
module line_sensor_adc_reader #(
  parameter int          CLK_DIV        = 13,
  parameter int          CS_HIGH_CYCLES = 26,
  parameter logic [11:0] THRESHOLD      = 12'd1000,
  parameter logic [2:0]  LEFT_CH        = 3'd0,
  parameter logic [2:0]  CENTER_CH      = 3'd1,
  parameter logic [2:0]  RIGHT_CH       = 3'd2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_din,
  input  logic        adc_dout,
  output logic [11:0] left_sample,
  output logic [11:0] center_sample,
  output logic [11:0] right_sample,
  output logic        sample_valid,
  output logic [3:0]  bot_orientation
);

  localparam int CNT_MAX = (CLK_DIV > CS_HIGH_CYCLES) ? CLK_DIV : CS_HIGH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_GAP, S_LOW, S_HIGH} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_tc;
  logic [3:0]       bit_idx;
  logic [3:0]       bit_nxt;
  logic             frame_start, frame_end, sclk_rise, sclk_fall;
  logic             restart;
  logic [1:0]       cur_ch, own_ch;
  logic             own_vld;
  logic [2:0]       cur_addr;
  logic             din_nxt;
  logic [11:0]      shift;

  function automatic logic [3:0] orient(input logic [2:0] lcr);
    case (lcr)
      3'b010:  orient = 4'd2;
      3'b100:  orient = 4'd1;
      3'b001:  orient = 4'd3;
      3'b110:  orient = 4'd5;
      3'b011:  orient = 4'd4;
      3'b111:  orient = 4'd6;
      3'b000:  orient = 4'd7;
      default: orient = 4'd0;
    endcase
  endfunction

  // terminal count depends on which phase is being timed
  always_comb begin
    if (state == S_GAP) cnt_tc = (cnt == CNT_W'(CS_HIGH_CYCLES - 1));
    else                cnt_tc = (cnt == CNT_W'(CLK_DIV - 1));
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_GAP;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_GAP:   if (cnt_tc && enable) state_nxt = S_LOW;
      S_LOW:   if (cnt_tc) state_nxt = S_HIGH;
      S_HIGH:  if (cnt_tc) state_nxt = (bit_idx == 4'd15) ? S_GAP : S_LOW;
      default: state_nxt = S_GAP;
    endcase
  end

  // SPI framing outputs decoded from state
  always_comb begin
    adc_cs_n = (state == S_GAP);
    adc_sclk = (state != S_LOW);
  end

  // frame events and per-bit address decode
  always_comb begin
    frame_start = (state == S_GAP) && cnt_tc && enable;
    sclk_rise   = (state == S_LOW) && cnt_tc;
    sclk_fall   = (state == S_HIGH) && cnt_tc && (bit_idx != 4'd15);
    frame_end   = (state == S_HIGH) && cnt_tc && (bit_idx == 4'd15);
    bit_nxt     = bit_idx + 4'd1;
    case (cur_ch)
      2'd0:    cur_addr = LEFT_CH;
      2'd1:    cur_addr = CENTER_CH;
      default: cur_addr = RIGHT_CH;
    endcase
    din_nxt = 1'b0;
    case (bit_nxt)
      4'd2:    din_nxt = cur_addr[2];
      4'd3:    din_nxt = cur_addr[1];
      4'd4:    din_nxt = cur_addr[0];
      default: din_nxt = 1'b0;
    endcase
  end

  // phase counter: restarts on every state change, holds at terminal in an idle gap
  always_ff @(posedge clk) begin
    if (reset)                   cnt <= '0;
    else if (state != state_nxt) cnt <= '0;
    else if (!cnt_tc)            cnt <= cnt + 1'b1;
  end

  // bit index, din and receive shift register
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_idx <= 4'd0;
      adc_din <= 1'b0;
      shift   <= 12'd0;
    end else begin
      if (frame_start) begin
        bit_idx <= 4'd0;
        adc_din <= 1'b0;
      end else if (sclk_fall) begin
        bit_idx <= bit_nxt;
        adc_din <= din_nxt;
      end else if (frame_end) begin
        adc_din <= 1'b0;
      end
      if (sclk_rise && (bit_idx >= 4'd4)) shift <= {shift[10:0], adc_dout};
    end
  end

  // channel rotation; data of each frame belongs to the previous frame's channel
  always_ff @(posedge clk) begin
    if (reset) begin
      restart <= 1'b1;
      cur_ch  <= 2'd0;
      own_ch  <= 2'd0;
      own_vld <= 1'b0;
    end else begin
      if ((state == S_GAP) && cnt_tc && !enable) restart <= 1'b1;
      if (frame_start) begin
        if (restart) begin
          cur_ch  <= 2'd0;
          own_vld <= 1'b0;
          restart <= 1'b0;
        end else begin
          own_ch  <= cur_ch;
          own_vld <= 1'b1;
          cur_ch  <= (cur_ch == 2'd2) ? 2'd0 : cur_ch + 2'd1;
        end
      end
    end
  end

  // sample registers, scan strobe and orientation, all updated at frame end
  always_ff @(posedge clk) begin
    if (reset) begin
      left_sample     <= 12'd0;
      center_sample   <= 12'd0;
      right_sample    <= 12'd0;
      sample_valid    <= 1'b0;
      bot_orientation <= 4'd0;
    end else begin
      sample_valid <= 1'b0;
      if (frame_end && own_vld) begin
        case (own_ch)
          2'd0: left_sample   <= shift;
          2'd1: center_sample <= shift;
          default: begin
            right_sample    <= shift;
            sample_valid    <= 1'b1;
            bot_orientation <= orient({left_sample < THRESHOLD,
                                       center_sample < THRESHOLD,
                                       shift < THRESHOLD});
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_line_sensor_adc_reader.sv
// Testbench for line_sensor_adc_reader: ADC128S022 behavioural model plus
// table-driven and randomized scan checks.
module tb_line_sensor_adc_reader;

  localparam int CLK_DIV = 13;
  localparam int CS_HIGH = 26;
  localparam int FRAME   = 32 * CLK_DIV + CS_HIGH;
  localparam int TH      = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        adc_dout = 1'b0;
  logic        adc_cs_n, adc_sclk, adc_din, sample_valid;
  logic [11:0] left_sample, center_sample, right_sample;
  logic [3:0]  bot_orientation;

  int n_checks = 0;
  int n_fail = 0;

  logic [11:0] vals [0:7];
  int code_lut [0:7] = '{7, 3, 2, 4, 1, 0, 5, 6};

  typedef struct {
    int addr;
    int low_cnt;
    int rises;
    bit bad;
    int gap;
  } frame_t;
  frame_t flog[$];

  typedef struct {
    logic [11:0] l, c, r;
    int          code;
  } vec_t;
  vec_t vecs [0:9];

  line_sensor_adc_reader #(
    .CLK_DIV(CLK_DIV), .CS_HIGH_CYCLES(CS_HIGH), .THRESHOLD(12'd1000),
    .LEFT_CH(3'd0), .CENTER_CH(3'd1), .RIGHT_CH(3'd2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_din(adc_din), .adc_dout(adc_dout),
    .left_sample(left_sample), .center_sample(center_sample), .right_sample(right_sample),
    .sample_valid(sample_valid), .bot_orientation(bot_orientation)
  );

  always #10 clk = ~clk;

  // ADC model: latches the address in frame k and returns that channel's value in frame k+1
  int          m_bit = 0, m_run = 0, m_low = 0, m_rises = 0, m_gap = 0, m_start_gap = 0;
  bit          m_bad = 0;
  logic [2:0]  m_cap = 3'd0, m_prev_addr = 3'd0;
  logic [11:0] m_word = 12'd0;
  logic        m_prev_cs = 1'b1, m_prev_sclk = 1'b1;

  always @(negedge clk) begin
    if (m_prev_cs && !adc_cs_n) begin
      m_bit = 0; m_run = 1; m_low = 1; m_rises = 0; m_bad = 0; m_cap = 3'd0;
      m_word = vals[m_prev_addr];
      m_start_gap = m_gap;
      adc_dout = 1'b0;
    end else if (!adc_cs_n) begin
      m_low++;
      if (adc_sclk != m_prev_sclk) begin
        if (m_run != CLK_DIV) m_bad = 1;
        m_run = 1;
        if (adc_sclk) begin
          m_rises++;
          if (m_bit >= 2 && m_bit <= 4) m_cap = {m_cap[1:0], adc_din};
        end else begin
          m_bit++;
          adc_dout = (m_bit >= 4) ? m_word[15 - m_bit] : 1'b0;
        end
      end else begin
        m_run++;
      end
    end else if (!m_prev_cs && adc_cs_n) begin
      if (m_run != CLK_DIV) m_bad = 1;
      flog.push_back('{addr: int'(m_cap), low_cnt: m_low, rises: m_rises, bad: m_bad, gap: m_start_gap});
      m_prev_addr = m_cap;
      m_gap = 1;
      adc_dout = 1'b0;
    end else begin
      m_gap++;
    end
    m_prev_cs = adc_cs_n;
    m_prev_sclk = adc_sclk;
  end

  function automatic int ref_code(input int l, input int c, input int r);
    int p;
    p = ((l < TH) ? 4 : 0) + ((c < TH) ? 2 : 0) + ((r < TH) ? 1 : 0);
    return code_lut[p];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name, input int budget);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event not seen within %0d clks", name, budget);
  endtask

  task automatic wait_valid(input int budget, output int cyc);
    bit done;
    done = 0; cyc = 0;
    while (!done) begin
      @(posedge clk); #1; cyc++;
      if (sample_valid) done = 1;
      else if (cyc >= budget) begin timeout("wait_valid", budget); done = 1; end
    end
  endtask

  task automatic wait_cs(input logic lvl, input int budget, output int cyc);
    bit done;
    done = 0; cyc = 0;
    while (!done) begin
      @(posedge clk); #1; cyc++;
      if (adc_cs_n == lvl) done = 1;
      else if (cyc >= budget) begin timeout("wait_cs", budget); done = 1; end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check_scan(input string name, input int l, input int c, input int r, input int code);
    check({name, " left_sample"}, int'(left_sample), l);
    check({name, " center_sample"}, int'(center_sample), c);
    check({name, " right_sample"}, int'(right_sample), r);
    check({name, " bot_orientation"}, int'(bot_orientation), code);
  endtask

  initial begin
    int c, total, base, cval, lows;
    int l, ce, r, p;

    vecs[0] = '{3000, 3000, 3000, 7};
    vecs[1] = '{3000, 3000,  500, 3};
    vecs[2] = '{3000,  500, 3000, 2};
    vecs[3] = '{3000,  500,  500, 4};
    vecs[4] = '{ 500, 3000, 3000, 1};
    vecs[5] = '{ 500, 3000,  500, 0};
    vecs[6] = '{ 500,  500, 3000, 5};
    vecs[7] = '{ 500,  500,  500, 6};
    vecs[8] = '{3000, 1000, 3000, 7};
    vecs[9] = '{3000,  999, 3000, 2};

    for (int i = 0; i < 8; i++) vals[i] = 12'd0;
    vals[0] = 12'd3000; vals[1] = 12'd200; vals[2] = 12'd3000;

    // reset and idle observation
    do_reset();
    base = flog.size();
    total = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1; total++;
      check("reset idle cs/sclk/valid/orient/din",
            int'({adc_cs_n, adc_sclk, sample_valid, bot_orientation, adc_din}), int'({1'b1, 1'b1, 1'b0, 4'd0, 1'b0}));
    end
    check("reset left_sample", int'(left_sample), 0);

    wait_cs(1'b0, 100, c); total += c;
    check("first cs_n fall clk", total, CS_HIGH);
    wait_valid(2000, c); total += c;
    check("first sample_valid clk", total, 4 * FRAME);
    check("cs_n rises with sample_valid", int'(adc_cs_n), 1);
    check_scan("first scan", 3000, 200, 3000, 2);
    @(posedge clk); #1;
    check("sample_valid one clk", int'(sample_valid), 0);

    check("frames logged", flog.size(), base + 4);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("frame%0d address", k), flog[base + k].addr, k);
      check($sformatf("frame%0d cs low clks", k), flog[base + k].low_cnt, 16 * 2 * CLK_DIV);
      check($sformatf("frame%0d sclk rises", k), flog[base + k].rises, 16);
      check($sformatf("frame%0d phase ok", k), int'(flog[base + k].bad), 0);
      check($sformatf("frame%0d gap clks", k + 1), flog[base + k + 1].gap, CS_HIGH);
    end

    wait_valid(2000, c);
    check("sample_valid interval", c + 1, 3 * FRAME);

    // table vectors
    for (int i = 0; i < 10; i++) begin
      vals[0] = vecs[i].l; vals[1] = vecs[i].c; vals[2] = vecs[i].r;
      wait_valid(2000, c);
      check_scan($sformatf("vec%0d", i), int'(vecs[i].l), int'(vecs[i].c), int'(vecs[i].r), vecs[i].code);
      check($sformatf("vec%0d ref agrees", i), int'(bot_orientation),
            ref_code(int'(vecs[i].l), int'(vecs[i].c), int'(vecs[i].r)));
    end

    // randomized scans against the reference model
    for (int i = 0; i < 6; i++) begin
      p  = $urandom_range(0, 7);
      l  = p[2] ? $urandom_range(0, 999) : $urandom_range(1000, 4095);
      ce = p[1] ? $urandom_range(0, 999) : $urandom_range(1000, 4095);
      r  = p[0] ? $urandom_range(0, 999) : $urandom_range(1000, 4095);
      vals[0] = 12'(l); vals[1] = 12'(ce); vals[2] = 12'(r);
      wait_valid(2000, c);
      check_scan($sformatf("rand%0d", i), l, ce, r, ref_code(l, ce, r));
    end

    // reset at bit 8 of frame 5
    vals[0] = 12'd3000; vals[1] = 12'd200; vals[2] = 12'd3000;
    do_reset();
    wait_valid(2000, c);
    wait_cs(1'b0, 100, c);
    wait_cs(1'b1, 600, c);
    wait_cs(1'b0, 100, c);
    repeat (8 * 2 * CLK_DIV + 5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("midframe reset cs_n", int'(adc_cs_n), 1);
    check("midframe reset sclk", int'(adc_sclk), 1);
    check("midframe reset orientation", int'(bot_orientation), 0);
    check("midframe reset left_sample", int'(left_sample), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    base = flog.size();
    wait_cs(1'b0, 100, c);
    wait_cs(1'b1, 600, c);
    @(negedge clk); #1;
    check("post-reset frames logged", flog.size(), base + 1);
    check("post-reset frame address", flog[base].addr, 0);
    check("post-reset data discarded", int'({left_sample, center_sample, right_sample}), 0);

    // enable dropped at bit 3
    wait_valid(2500, c);
    vals[0] = 12'd1234;
    wait_cs(1'b0, 100, c);
    repeat (3 * 2 * CLK_DIV + 5) @(posedge clk);
    #1 enable = 1'b0;
    wait_cs(1'b1, 600, c);
    check("disable frame updates left", int'(left_sample), 1234);
    check("disable frame no valid", int'(sample_valid), 0);
    lows = 0;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      if (!adc_cs_n) lows++;
    end
    check("disabled no cs_n fall", lows, 0);
    cval = int'(center_sample);
    enable = 1'b1;
    wait_cs(1'b0, 100, c);
    check("restart frame start delay", c, 1);
    wait_cs(1'b1, 600, c);
    @(negedge clk); #1;
    check("restart frame address", flog[$].addr, 0);
    check("restart data discarded left", int'(left_sample), 1234);
    check("restart data discarded center", int'(center_sample), cval);
    wait_valid(2000, c);
    check_scan("after restart", 1234, 200, 3000, ref_code(1234, 200, 3000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
